// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: two-flop line synchronizer, mid-bit sampling FSM,
// and a one-word output register with ready/valid handshake and overrun pulse.
module uart_rx_cfg #(
  parameter int CLOCKS_PER_BIT = 100_000_000/9_600,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 clock_enable_i,
  input  logic                 rx_i,
  input  logic                 m_ready_i,
  output logic                 m_valid_o,
  output logic [DATA_BITS-1:0] m_data_o,
  output logic                 m_parity_err_o,
  output logic                 m_frame_err_o,
  output logic                 overrun_o
);

  // state  | meaning
  // IDLE   | waiting for a falling edge on the synchronized line
  // START  | half-bit wait, then confirm the start bit is still low
  // DATA   | sampling DATA_BITS bits, LSB first
  // PARITY | sampling the parity bit
  // STOP   | sampling STOP_BITS stop bits, completing the frame on the last
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam logic [TW-1:0] FULL_LD   = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LD   = TW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 ovr_q, ovr_d;

  logic tick;
  logic par_x;
  logic complete;
  logic stall;

  // Down-counter reaching zero on an enabled cycle marks a sample point.
  assign tick  = clock_enable_i & (timer_q == '0);
  assign par_x = (^shift_q) ^ rx_s2_q;
  assign stall = valid_q & ~m_ready_i;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    complete  = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (rx_prev_q & ~rx_s2_q) begin
          state_d = S_START;
          timer_d = HALF_LD;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_s2_q) begin
            state_d   = S_DATA;
            timer_d   = FULL_LD;
            bit_cnt_d = 4'd0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            timer_d = '0;
          end
        end else if (clock_enable_i) begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rx_s2_q, shift_q[DATA_BITS-1:1]};
          timer_d = FULL_LD;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = 4'd0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (clock_enable_i) begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_PARITY: begin
        if (tick) begin
          perr_d  = (PARITY == 1) ? ~par_x : par_x;
          state_d = S_STOP;
          timer_d = FULL_LD;
        end else if (clock_enable_i) begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!rx_s2_q) ferr_d = 1'b1;
          if (bit_cnt_q == LAST_STOP) begin
            complete  = 1'b1;
            state_d   = S_IDLE;
            timer_d   = '0;
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            timer_d   = FULL_LD;
          end
        end else if (clock_enable_i) begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = 1'b0;
    if (complete) begin
      if (stall) begin
        ovr_d = 1'b1;
      end else begin
        valid_d    = 1'b1;
        data_d     = shift_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_q | ~rx_s2_q;
      end
    end else if (valid_q & m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign m_valid_o      = valid_q;
  assign m_data_o       = data_q;
  assign m_parity_err_o = perr_out_q;
  assign m_frame_err_o  = ferr_out_q;
  assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg at 16 clocks/bit, 8 data bits, even parity, 1 stop bit.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       clock_enable_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       m_ready_i = 1'b1;
  logic       m_valid_o;
  logic [7:0] m_data_o;
  logic       m_parity_err_o;
  logic       m_frame_err_o;
  logic       overrun_o;

  int total = 0;
  int bad   = 0;
  int rd    = 0;

  // Monitor-owned event log
  logic [7:0] got_d [64];
  logic       got_p [64];
  logic       got_f [64];
  int         got_n = 0;
  int         valid_cycles = 0;
  int         ovr_cnt = 0;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t vecs [7];

  uart_rx_cfg #(
    .CLOCKS_PER_BIT(CPB),
    .DATA_BITS(8),
    .PARITY(2),
    .STOP_BITS(1)
  ) dut (
    .clk(clk),
    .reset_i(reset_i),
    .clock_enable_i(clock_enable_i),
    .rx_i(rx_i),
    .m_ready_i(m_ready_i),
    .m_valid_o(m_valid_o),
    .m_data_o(m_data_o),
    .m_parity_err_o(m_parity_err_o),
    .m_frame_err_o(m_frame_err_o),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_valid_o) valid_cycles = valid_cycles + 1;
    if (overrun_o) ovr_cnt = ovr_cnt + 1;
    if (m_valid_o && m_ready_i && got_n < 64) begin
      got_d[got_n] = m_data_o;
      got_p[got_n] = m_parity_err_o;
      got_f[got_n] = m_frame_err_o;
      got_n = got_n + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic expect_word(input string nm, input int ed, input int ep, input int ef);
    chk({nm, "_count"}, got_n - rd, 1);
    if (got_n > rd) begin
      chk({nm, "_data"}, int'(got_d[rd]), ed);
      chk({nm, "_perr"}, int'(got_p[rd]), ep);
      chk({nm, "_ferr"}, int'(got_f[rd]), ef);
    end
    rd = got_n;
  endtask

  task automatic expect_none(input string nm);
    chk(nm, got_n - rd, 0);
    rd = got_n;
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 m_ready_i = r;
  endtask

  initial begin
    int v0;
    int o0;

    vecs[0] = '{d: 8'hA5, p: 1'b0, s: 1'b1, ed: 8'hA5, ep: 1'b0, ef: 1'b0};
    vecs[1] = '{d: 8'hA5, p: 1'b1, s: 1'b1, ed: 8'hA5, ep: 1'b1, ef: 1'b0};
    vecs[2] = '{d: 8'h00, p: 1'b0, s: 1'b1, ed: 8'h00, ep: 1'b0, ef: 1'b0};
    vecs[3] = '{d: 8'hFF, p: 1'b0, s: 1'b1, ed: 8'hFF, ep: 1'b0, ef: 1'b0};
    vecs[4] = '{d: 8'h01, p: 1'b1, s: 1'b1, ed: 8'h01, ep: 1'b0, ef: 1'b0};
    vecs[5] = '{d: 8'h80, p: 1'b0, s: 1'b1, ed: 8'h80, ep: 1'b1, ef: 1'b0};
    vecs[6] = '{d: 8'h7E, p: 1'b1, s: 1'b0, ed: 8'h7E, ep: 1'b1, ef: 1'b1};

    // Reset state, checked before any clock edge
    #1;
    chk("rst_valid", int'(m_valid_o), 0);
    chk("rst_data",  int'(m_data_o), 0);
    chk("rst_perr",  int'(m_parity_err_o), 0);
    chk("rst_ferr",  int'(m_frame_err_o), 0);
    chk("rst_ovr",   int'(overrun_o), 0);
    repeat (4) @(negedge clk);
    reset_i = 1'b0;
    idle(20);

    for (int i = 0; i < 7; i++) begin
      v0 = valid_cycles;
      o0 = ovr_cnt;
      send_frame(vecs[i].d, vecs[i].p, vecs[i].s);
      idle(20);
      expect_word($sformatf("vec%0d", i), int'(vecs[i].ed), int'(vecs[i].ep), int'(vecs[i].ef));
      chk($sformatf("vec%0d_valid_cycles", i), valid_cycles - v0, 1);
      chk($sformatf("vec%0d_ovr", i), ovr_cnt - o0, 0);
    end

    // Stop bit low, line stays low: frame error, no restart until high then falling
    send_frame(8'h3C, 1'b0, 1'b0);
    rx_i = 1'b0;
    repeat (40) @(negedge clk);
    expect_word("low_hold", 8'h3C, 0, 1);
    chk("low_hold_valid", int'(m_valid_o), 0);
    idle(20);
    expect_none("low_hold_no_second");
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(20);
    expect_word("after_low", 8'hA5, 0, 0);

    // Short glitch is rejected and the receiver returns to idle
    v0 = valid_cycles;
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    idle(200);
    expect_none("glitch_word");
    chk("glitch_valid_cycles", valid_cycles - v0, 0);
    send_frame(8'hC3, 1'b0, 1'b1);
    idle(20);
    expect_word("after_glitch", 8'hC3, 0, 0);

    // Stall: second frame dropped with one overrun pulse
    set_ready(1'b0);
    o0 = ovr_cnt;
    idle(4);
    send_frame(8'h11, 1'b0, 1'b1);
    idle(20);
    chk("stall1_valid", int'(m_valid_o), 1);
    chk("stall1_data", int'(m_data_o), 8'h11);
    chk("stall1_ovr", ovr_cnt - o0, 0);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(20);
    chk("stall2_valid", int'(m_valid_o), 1);
    chk("stall2_data", int'(m_data_o), 8'h11);
    chk("stall2_ovr", ovr_cnt - o0, 1);
    expect_none("stall_no_handshake");
    set_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("stall_release_valid", int'(m_valid_o), 0);
    expect_word("stall_release", 8'h11, 0, 0);
    chk("stall_final_ovr", ovr_cnt - o0, 1);

    // Reset mid-frame with a held, flagged word
    set_ready(1'b0);
    idle(4);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    chk("held_valid", int'(m_valid_o), 1);
    chk("held_perr", int'(m_parity_err_o), 1);
    chk("held_ferr", int'(m_frame_err_o), 1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx_i = 1'b1;
    repeat (8) @(negedge clk);
    #2 reset_i = 1'b1;
    #1;
    chk("midrst_valid", int'(m_valid_o), 0);
    chk("midrst_data", int'(m_data_o), 0);
    chk("midrst_perr", int'(m_parity_err_o), 0);
    chk("midrst_ferr", int'(m_frame_err_o), 0);
    chk("midrst_ovr", int'(overrun_o), 0);
    repeat (3) @(negedge clk);
    #2 reset_i = 1'b0;
    set_ready(1'b1);
    v0 = valid_cycles;
    idle(200);
    expect_none("midrst_no_partial");
    chk("midrst_no_valid", valid_cycles - v0, 0);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(20);
    expect_word("post_rst", 8'h5A, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The module SHALL have parameter CLOCKS_PER_BIT, default 100_000_000/9_600, meaning enabled clock ticks per bit period, legal range >= 4.
REQ-002 The module SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-003 The module SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 The module SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame, legal 1 or 2.
REQ-005 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-006 The module SHALL have port reset_i, input, 1 bit, asynchronous active-high reset.
REQ-007 The module SHALL have port clock_enable_i, input, 1 bit, qualifying every bit-timer advance.
REQ-008 The module SHALL have port rx_i, input, 1 bit, asynchronous serial line, idle high.
REQ-009 The module SHALL have port m_ready_i, input, 1 bit, downstream ready.
REQ-010 The module SHALL have port m_valid_o, output, 1 bit, received word valid.
REQ-011 The module SHALL have port m_data_o, output, DATA_BITS bits, received word, bit 0 first on the line.
REQ-012 The module SHALL have port m_parity_err_o, output, 1 bit, parity mismatch flag travelling with m_data_o.
REQ-013 The module SHALL have port m_frame_err_o, output, 1 bit, stop-bit error flag travelling with m_data_o.
REQ-014 The module SHALL have port overrun_o, output, 1 bit, one-cycle pulse when a completed frame is dropped.

Function
REQ-015 rx_i SHALL pass through a two-flop synchronizer before use; all line references below mean the synchronized value.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-017 The bit timer SHALL be $clog2(CLOCKS_PER_BIT) bits wide and SHALL advance only in cycles with clock_enable_i high.
REQ-018 IDLE -> START SHALL occur on a line falling edge (previous sample 1, current sample 0); a line held low SHALL never start a frame.
REQ-019 START SHALL sample the line after CLOCKS_PER_BIT/2 (floor) ticks: 0 -> DATA, 1 -> IDLE (glitch rejected, no output).
REQ-020 DATA SHALL sample DATA_BITS bits LSB first, one every CLOCKS_PER_BIT ticks, then go to PARITY if PARITY != 0, else STOP.
REQ-021 PARITY SHALL sample one bit; m_parity_err_o for the frame SHALL be 1 when data XOR parity bit is 0 for odd and 1 for even; it SHALL be 0 when PARITY = 0.
REQ-022 STOP SHALL sample STOP_BITS bits; any sampled 0 SHALL set m_frame_err_o for the frame.
REQ-023 At the last stop-bit sample the FSM SHALL return to IDLE in the next cycle, so a start edge arriving in the second half of the stop bit is accepted.
REQ-024 Completion latency: m_valid_o SHALL rise on the cycle after the last stop-bit sample tick.
REQ-025 Stall is defined as m_valid_o high and m_ready_i low.
REQ-026 A frame completing without stall SHALL load m_data_o, m_parity_err_o and m_frame_err_o and set m_valid_o.
REQ-027 A frame completing with stall SHALL be discarded, with held outputs unchanged and overrun_o pulsed for one cycle.
REQ-028 Simultaneous handshake (m_valid_o and m_ready_i high) and frame completion SHALL load the new word with m_valid_o staying high and no overrun.
REQ-029 A handshake without completion SHALL clear m_valid_o in the next cycle.
REQ-030 m_data_o and both error flags SHALL hold stable while m_valid_o is high and not accepted.
REQ-031 Frames with parity or framing errors SHALL still be delivered, with flags set.

Reset
REQ-032 reset_i high SHALL immediately, without clk, force FSM IDLE, timer 0, synchronizer flops 1, m_valid_o 0, m_data_o 0, both error flags 0, and overrun_o 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; reception SHALL resume only on the first falling edge after reset release.

Verification (CLOCKS_PER_BIT=16, DATA_BITS=8, PARITY=2, STOP_BITS=1, clock_enable_i=1)
REQ-034 Bench SHALL cover: frame 0xA5, parity bit 0, stop bit 1, m_ready_i=1 -> m_valid_o for 1 cycle, m_data_o=0xA5, both errors 0.
REQ-035 Bench SHALL cover: frame 0xA5 with parity bit 1 -> m_data_o=0xA5, m_parity_err_o=1, m_frame_err_o=0.
REQ-036 Bench SHALL cover: frame 0x3C with stop bit 0 and line held low for 40 clocks -> m_frame_err_o=1, and no second frame until the line goes high and then falls.
REQ-037 Bench SHALL cover: line low for 4 clocks, then high -> no m_valid_o and FSM back in IDLE.
REQ-038 Bench SHALL cover: m_ready_i=0, frames 0x11 then 0x22 -> m_data_o stays 0x11, overrun_o pulses once at 0x22 completion, and m_ready_i=1 then clears m_valid_o.
REQ-039 Bench SHALL cover: reset_i pulsed during data bit 3 -> outputs 0 at once, and the next 0x5A frame is received correctly with no errors.
